hs4_rx_fifo: RTL and testbench



---
 rtl/hs4_pkg.sv | 19 +
 rtl/hs4_sync_fifo.sv | 58 +++++
 rtl/hs4_rx_fifo.sv | 117 +++++++++++
 tb/tb_hs4_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// hs4_pkg: shared definitions for the 4-phase REQ/ACK receiver slice.
//   hs4_state_t - handshake FSM states (IDLE waits for a request, ACK holds
//                 the acknowledge until the request is released).
//   HS4_DATA_W  - default word width, shared with the matching initiator.
//   hs4PtrW()   - FIFO pointer width: address bits plus one wrap bit.
package hs4_pkg;

    localparam int HS4_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs4_state_t;

    function automatic int hs4PtrW(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs4_sync_fifo.sv
// hs4_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst  - clock, asynchronous active-high reset (empties the FIFO)
//   push      - write pushData this edge (ignored while full)
//   pushData  - word to write
//   pop       - drop the head word this edge (ignored while empty)
//   full      - no free entry (registered occupancy)
//   empty     - no stored entry
//   head      - oldest stored word, reads 0 while empty
// DEPTH must be a power of two, at least 2.
module hs4_sync_fifo
    import hs4_pkg::*;
#(
    parameter int DATA_W = HS4_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    // AW address bits; bit AW of each pointer is the wrap flag.
    localparam int AW = hs4PtrW(DEPTH) - 1;

    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              doPush;
    logic              doPop;

    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

    // Same address with differing wrap bits means the writer lapped the reader.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/hs4_rx_fifo.sv
// hs4_rx_fifo: 4-phase REQ/ACK responder feeding a valid/ready FIFO output.
//   clk, rst   - single clock; asynchronous active-high reset
//   req_in     - upstream request level (4-phase)
//   data_in    - upstream word, stable while req_in is high
//   ack_out    - acknowledge to upstream
//   dout       - FIFO head word (0 while empty)
//   dout_valid - FIFO not empty
//   dout_ready - downstream takes dout this cycle
//   rx_count   - words accepted since reset, wraps
//   proto_err  - sticky: request withdrawn while stalled, or data changed
//                while acknowledged
// Optional: HS4_RX_REQ_SYNC_EN puts req_in through a 2-flop synchronizer,
// adding two edges to both capture and release latency.
module hs4_rx_fifo
    import hs4_pkg::*;
#(
    parameter int DATA_W = HS4_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  rx_count,
    output logic              proto_err
);

    hs4_state_t        state;
    hs4_state_t        nextState;
    logic              reqS;
    logic              push;
    logic              full;
    logic              empty;
    logic              stalled;
    logic              withdrawn;
    logic              dataChanged;
    logic [DATA_W-1:0] capWord;

`ifdef HS4_RX_REQ_SYNC_EN
    logic [1:0] reqSync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) reqSync <= '0;
        else     reqSync <= {reqSync[0], req_in};
    end

    assign reqS = reqSync[1];
`else
    assign reqS = req_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // full is the occupancy registered before this edge, so a pop on the
    // same edge cannot make room for a push; that push lands next cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (reqS && !full) nextState = ACK;
            ACK:     if (!reqS)         nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ack_out is a pure state decode, so it drops the moment rst asserts.
    always_comb begin
        ack_out = (state == ACK);
        push    = (state == IDLE) && reqS && !full;
    end

    // With the synchronizer, req_s lags req_in; once upstream drops req_in it
    // may legally change data_in, so the data check also needs the live level.
    assign withdrawn   = (state == IDLE) && stalled && !reqS;
    assign dataChanged = (state == ACK) && reqS && req_in && (data_in != capWord);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count  <= '0;
            capWord   <= '0;
            stalled   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                rx_count <= rx_count + CNT_W'(1);
                capWord  <= data_in;
            end
            // A request seen in IDLE but refused because the FIFO was full.
            stalled <= (state == IDLE) && reqS && full;
            if (withdrawn || dataChanged) proto_err <= 1'b1;
        end
    end

    assign dout_valid = ~empty;

    hs4_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (data_in),
        .pop      (dout_valid & dout_ready),
        .full     (full),
        .empty    (empty),
        .head     (dout)
    );

endmodule

// File: tb/tb_hs4_rx_fifo.sv
module tb_hs4_rx_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
`ifdef HS4_RX_REQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reqIn = 1'b0;
    logic [DATA_W-1:0] dataIn = '0;
    logic              doutReady = 1'b0;
    logic              ackOut;
    logic [DATA_W-1:0] dout;
    logic              doutValid;
    logic [CNT_W-1:0]  rxCount;
    logic              protoErr;

    hs4_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (reqIn),
        .data_in    (dataIn),
        .ack_out    (ackOut),
        .dout       (dout),
        .dout_valid (doutValid),
        .dout_ready (doutReady),
        .rx_count   (rxCount),
        .proto_err  (protoErr)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Reference model: the FIFO is a queue, the handshake a "waiting for
    // release" flag, the synchronizer a two-deep history of req_in.
    logic [DATA_W-1:0] mQ[$];
    logic [DATA_W-1:0] popped[$];
    bit                mAck;
    bit                mErr;
    bit                mStalled;
    bit   [1:0]        mSync;
    logic [CNT_W-1:0]  mCnt;
    logic [DATA_W-1:0] mCap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mAck = 0; mErr = 0; mStalled = 0; mSync = '0;
        mCnt = '0; mCap = '0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic modelEdge();
        bit reqS, isFull, doPush, doPop;
        reqS   = SYNC ? mSync[1] : reqIn;
        isFull = (mQ.size() == DEPTH);
        doPush = !mAck && reqS && !isFull;
        doPop  = (mQ.size() != 0) && doutReady;
        if ((!mAck && mStalled && !reqS) || (mAck && reqS && reqIn && dataIn != mCap))
            mErr = 1;
        mStalled = !mAck && reqS && isFull;
        if (doPop) void'(mQ.pop_front());
        if (doPush) begin
            mQ.push_back(dataIn);
            mCap = dataIn;
            mCnt = mCnt + 1'b1;
            mAck = 1;
        end else if (mAck && !reqS) begin
            mAck = 0;
        end
        mSync = {mSync[0], reqIn};
    endtask

    task automatic compareModel();
        logic [DATA_W-1:0] eD;
        eD = (mQ.size() != 0) ? mQ[0] : '0;
        check("ack_out",    64'(ackOut),    64'(mAck));
        check("dout_valid", 64'(doutValid), 64'(mQ.size() != 0));
        check("dout",       64'(dout),      64'(eD));
        check("rx_count",   64'(rxCount),   64'(mCnt));
        check("proto_err",  64'(protoErr),  64'(mErr));
    endtask

    // One clock: model steps with the pre-edge inputs, outputs sampled 1 after.
    task automatic tick();
        logic              pv, pr;
        logic [DATA_W-1:0] pd;
        pv = doutValid; pd = dout; pr = doutReady;
        modelEdge();
        @(posedge clk);
        #1;
        if (pv && pr) popped.push_back(pd);
        compareModel();
    endtask

    // Asserted and checked between clock edges: reset must act without clk.
    task automatic doReset();
        reqIn = 1'b0;
        rst = 1'b1;
        #2;
        modelReset();
        check("rst ack_out",    64'(ackOut),    64'(0));
        check("rst dout_valid", 64'(doutValid), 64'(0));
        check("rst dout",       64'(dout),      64'(0));
        check("rst rx_count",   64'(rxCount),   64'(0));
        check("rst proto_err",  64'(protoErr),  64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sendWord(input logic [DATA_W-1:0] w);
        int n;
        reqIn = 1'b1;
        dataIn = w;
        n = 0;
        while (!ackOut && n < 30) begin tick(); n++; end
        check("send ack rise", 64'(ackOut), 64'(1));
        reqIn = 1'b0;
        n = 0;
        while (ackOut && n < 30) begin tick(); n++; end
        check("send ack fall", 64'(ackOut), 64'(0));
    endtask

    typedef struct {
        logic              req;
        logic [DATA_W-1:0] data;
        logic              ready;
        logic              eAck;
        logic              eValid;
        logic [DATA_W-1:0] eDout;
        logic [CNT_W-1:0]  eCnt;
        logic              eErr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 32'h5, 16'd1, 1'b0};
        tbl[1] = '{1'b1, 32'h5, 1'b1, 1'b1, 1'b0, 32'h0, 16'd1, 1'b0};
        tbl[2] = '{1'b0, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1, 1'b0};
        tbl[3] = '{1'b0, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1, 1'b0};
        tbl[4] = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 16'd2, 1'b0};
        tbl[5] = '{1'b0, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 16'd2, 1'b0};
        tbl[6] = '{1'b0, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0, 16'd2, 1'b0};

        doReset();

`ifndef HS4_RX_REQ_SYNC_EN
        // Single-word handshake and a held word, vector by vector.
        for (int i = 0; i < 7; i++) begin
            reqIn = tbl[i].req; dataIn = tbl[i].data; doutReady = tbl[i].ready;
            tick();
            check($sformatf("tbl[%0d] ack", i),   64'(ackOut),    64'(tbl[i].eAck));
            check($sformatf("tbl[%0d] valid", i), 64'(doutValid), 64'(tbl[i].eValid));
            check($sformatf("tbl[%0d] dout", i),  64'(dout),      64'(tbl[i].eDout));
            check($sformatf("tbl[%0d] cnt", i),   64'(rxCount),   64'(tbl[i].eCnt));
            check($sformatf("tbl[%0d] err", i),   64'(protoErr),  64'(tbl[i].eErr));
        end
`else
        // Synchronizer: capture and release each take two extra edges.
        doutReady = 1'b0;
        reqIn = 1'b1; dataIn = 32'hCAFE0001;
        tick(); check("sync edge1 ack", 64'(ackOut), 64'(0));
        tick(); check("sync edge2 ack", 64'(ackOut), 64'(0));
        tick(); check("sync edge3 ack", 64'(ackOut), 64'(1));
        check("sync captured", 64'(dout), 64'(32'hCAFE0001));
        reqIn = 1'b0;
        tick(); check("sync rel1 ack", 64'(ackOut), 64'(1));
        tick(); check("sync rel2 ack", 64'(ackOut), 64'(1));
        tick(); check("sync rel3 ack", 64'(ackOut), 64'(0));
`endif

        // Ten back-to-back words.
        doReset();
        doutReady = 1'b1;
        popped.delete();
        for (int i = 0; i < 10; i++) sendWord(DATA_W'(i));
        for (int i = 0; i < 3; i++) tick();
        check("b2b count", 64'(popped.size()), 64'(10));
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check($sformatf("b2b word %0d", i), 64'(popped[i]), 64'(i));
        check("b2b rx_count",  64'(rxCount),  64'(10));
        check("b2b proto_err", 64'(protoErr), 64'(0));

        // Backpressure: fifth word waits for a pop, then one more edge.
        doReset();
        doutReady = 1'b0;
        popped.delete();
        for (int i = 0; i < DEPTH; i++) sendWord(DATA_W'(i));
        reqIn = 1'b1; dataIn = 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp stalled ack", 64'(ackOut), 64'(0));
        end
        doutReady = 1'b1;
        tick();
        check("bp pop edge ack", 64'(ackOut), 64'(0));
        doutReady = 1'b0;
        tick();
        check("bp ack after pop", 64'(ackOut), 64'(1));
        check("bp rx_count", 64'(rxCount), 64'(5));
        reqIn = 1'b0;
        doutReady = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp popped count", 64'(popped.size()), 64'(5));
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check($sformatf("bp word %0d", i), 64'(popped[i]), 64'(i));

        // Request withdrawn while stalled on a full FIFO.
        doReset();
        doutReady = 1'b0;
        popped.delete();
        for (int i = 0; i < DEPTH; i++) sendWord(DATA_W'(16 + i));
        reqIn = 1'b1; dataIn = 32'd99;
        for (int i = 0; i < 3; i++) tick();
        reqIn = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("withdraw err", 64'(protoErr), 64'(1));
        check("withdraw rx_count", 64'(rxCount), 64'(DEPTH));
        doutReady = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("withdraw err sticky", 64'(protoErr), 64'(1));
        check("withdraw popped count", 64'(popped.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < popped.size(); i++)
            check($sformatf("withdraw word %0d", i), 64'(popped[i]), 64'(16 + i));

        // Reset while acknowledging.
        doReset();
        doutReady = 1'b0;
        reqIn = 1'b1; dataIn = 32'h77;
        for (int i = 0; i < 6 && !ackOut; i++) tick();
        check("pre-reset ack", 64'(ackOut), 64'(1));
        doReset();

        // Randomized upstream/downstream against the model.
        for (int seg = 0; seg < 3; seg++) begin
            doReset();
            for (int c = 0; c < 600; c++) begin
                int r;
                r = $urandom_range(0, 63);
                if (!reqIn && !ackOut) begin
                    if (r < 32) begin reqIn = 1'b1; dataIn = $urandom; end
                end else if (reqIn && ackOut) begin
                    if (r < 32) reqIn = 1'b0;
                    else if (r == 63 && seg != 0) dataIn = dataIn ^ 32'h1;
                end else if (reqIn && !ackOut) begin
                    if (r == 0 && seg != 0) reqIn = 1'b0;
                end
                doutReady = ($urandom_range(0, 3) < ((seg == 1) ? 1 : 3));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

endmodule
